// File: rtl/a2d_rr_seq.sv
// a2d_rr_seq: round-robin A2D conversion sequencer that drives an SPI master.
// Each conversion runs two SPI transactions: channel select, a GAP_CYC idle gap, then read.
// Optional build macro A2D_LOAD_AVG_EN: lft_ld/rght_ld keep a rounded running average
// instead of loading each new sample directly.
module a2d_rr_seq #(
    parameter int unsigned GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SEL, GAP, READ} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [3:0]  gap_q, gap_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmplt_q, cmplt_d;
    logic [11:0] lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
    logic [2:0]  chnl;
    logic [11:0] smp, lft_new, rght_new;
    logic        unused_hi;

    // rr 0 selects ch0; rr 1..3 select ch4..ch6
    assign chnl      = (rr_q == 2'd0) ? 3'd0 : {1'b1, rr_q - 2'd1};
    assign smp       = rd_data[11:0];
    assign unused_hi = ^rd_data[15:12];

`ifdef A2D_LOAD_AVG_EN
    logic        lft_vld_q, rght_vld_q;
    logic [12:0] lft_sum, rght_sum;
    assign lft_sum  = {1'b0, lft_q} + {1'b0, smp} + 13'd1;
    assign rght_sum = {1'b0, rght_q} + {1'b0, smp} + 13'd1;
    assign lft_new  = lft_vld_q ? lft_sum[12:1] : smp;
    assign rght_new = rght_vld_q ? rght_sum[12:1] : smp;

    // The first sample after reset has nothing to average with, so it loads directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_vld_q  <= 1'b0;
            rght_vld_q <= 1'b0;
        end else if (state_q == READ && done) begin
            lft_vld_q  <= lft_vld_q | (rr_q == 2'd0);
            rght_vld_q <= rght_vld_q | (rr_q == 2'd1);
        end
    end
`else
    assign lft_new  = smp;
    assign rght_new = smp;
`endif

    // Next-state and next-output logic; wrt and cnv_cmplt default low so they only ever pulse
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        cmplt_d = 1'b0;
        lft_d   = lft_q;
        rght_d  = rght_q;
        steer_d = steer_q;
        batt_d  = batt_q;
        case (state_q)
            IDLE: if (nxt) begin
                wrt_d   = 1'b1;
                cmd_d   = {2'b00, chnl, 11'h000};
                state_d = SEL;
            end
            SEL: if (done) begin
                gap_d   = 4'(GAP_CYC);
                state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h0000;
                    state_d = READ;
                end
            end
            READ: if (done) begin
                lft_d   = (rr_q == 2'd0) ? lft_new : lft_q;
                rght_d  = (rr_q == 2'd1) ? rght_new : rght_q;
                steer_d = (rr_q == 2'd2) ? smp : steer_q;
                batt_d  = (rr_q == 2'd3) ? smp : batt_q;
                cmplt_d = 1'b1;
                rr_d    = rr_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, counter and registered outputs; reset abandons any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 2'd0;
            gap_q   <= 4'd0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            cmplt_q <= 1'b0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            steer_q <= 12'h000;
            batt_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            cmplt_q <= cmplt_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            steer_q <= steer_d;
            batt_q  <= batt_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign cnv_cmplt = cmplt_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_a2d_rr_seq.sv
// tb_a2d_rr_seq: vector table, directed corner sequences and randomized conversions for a2d_rr_seq.
module tb_a2d_rr_seq;
    localparam int GAP_CYC = 2;
`ifdef A2D_LOAD_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        clk, rst_n, nxt, done;
    logic [15:0] rd_data;
    logic        wrt, cnv_cmplt, busy;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    int checks = 0;
    int failures = 0;

    int          ch_of [4] = '{0, 4, 5, 6};
    int          m_rr;
    logic [11:0] m_res [4];
    bit          m_vld [4];
    logic        wrt_prev = 1'b0;

    typedef struct {
        bit          rst;
        logic [15:0] data;
        logic [15:0] cmd;
        int          idx;
        logic [11:0] val;
    } vec_t;
    vec_t tbl [6];

    a2d_rr_seq #(.GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .cnv_cmplt(cnv_cmplt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrt) begin
            checks++;
            if (wrt_prev) begin
                failures++;
                $display("FAIL wrt_back_to_back act=1 exp=0 t=%0t", $time);
            end
        end
        wrt_prev = wrt;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] dres(input int i);
        return (i == 0) ? lft_ld : (i == 1) ? rght_ld : (i == 2) ? steer_pot : batt;
    endfunction

    function automatic logic [11:0] upd(input int idx, input logic [11:0] s);
        if (AVG && idx < 2 && m_vld[idx]) return 12'((int'(m_res[idx]) + int'(s) + 1) / 2);
        return s;
    endfunction

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < 4; i++) begin
            m_res[i] = 12'h000;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wrt", wrt, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_cc", cnv_cmplt, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 4; i++) chk("rst_res", dres(i), 0);
        model_reset();
        step();
        chk("rst_hold_wrt", wrt, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_wrt", wrt, 0);
    endtask

    // mode 0: clean, mode 1: random waits plus spurious nxt/done, mode 2: nxt held high
    task automatic convert(input logic [15:0] data, input int mode,
                           output logic [15:0] c_sel, output logic [15:0] c_rd);
        int n;
        logic [15:0] xcmd;
        xcmd = 16'(ch_of[m_rr] * 2048);
        nxt = 1'b1;
        step();
        nxt = (mode == 2);
        c_sel = cmd;
        chk("sel_wrt", wrt, 1);
        chk("sel_cmd", cmd, xcmd);
        chk("sel_busy", busy, 1);
        n = (mode == 1) ? $urandom_range(0, 3) : 0;
        repeat (n) begin
            nxt = (mode == 2) | ((mode == 1) & ($urandom_range(0, 1) == 1));
            step();
            chk("sel_cmd_hold", cmd, xcmd);
            chk("sel_wrt_lo", wrt, 0);
        end
        done = 1'b1;
        rd_data = 16'($urandom);
        step();
        done = 1'b0;
        n = 0;
        while (!wrt && n < 40) begin
            n++;
            if (mode == 1) begin
                done = ($urandom_range(0, 1) == 1);
                nxt = ($urandom_range(0, 1) == 1);
            end
            step();
            done = 1'b0;
        end
        chk("gap_len", n, GAP_CYC);
        chk("rd_wrt", wrt, 1);
        chk("rd_cmd", cmd, 0);
        c_rd = cmd;
        n = (mode == 1) ? $urandom_range(0, 3) : 0;
        repeat (n) begin
            step();
            chk("rd_wait_wrt", wrt, 0);
            chk("rd_wait_cc", cnv_cmplt, 0);
        end
        done = 1'b1;
        rd_data = data;
        nxt = (mode == 2) | ((mode == 1) & ($urandom_range(0, 1) == 1));
        step();
        done = 1'b0;
        nxt = 1'b0;
        m_res[m_rr] = upd(m_rr, data[11:0]);
        m_vld[m_rr] = 1'b1;
        m_rr = (m_rr + 1) % 4;
        chk("cc", cnv_cmplt, 1);
        chk("done_busy", busy, 0);
        chk("done_wrt", wrt, 0);
        for (int i = 0; i < 4; i++) chk("res", dres(i), m_res[i]);
        done = (mode == 1) & ($urandom_range(0, 1) == 1);
        step();
        done = 1'b0;
        chk("cc_once", cnv_cmplt, 0);
        chk("no_restart", wrt, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [15:0] cs, cr;
        rst_n = 1'b0;
        nxt = 1'b0;
        done = 1'b0;
        rd_data = 16'h0000;
        model_reset();
        tbl[0] = '{1'b1, 16'h0ABC, 16'h0000, 0, 12'hABC};
        tbl[1] = '{1'b1, 16'h0111, 16'h0000, 0, 12'h111};
        tbl[2] = '{1'b0, 16'h0222, 16'h2000, 1, 12'h222};
        tbl[3] = '{1'b0, 16'h0333, 16'h2800, 2, 12'h333};
        tbl[4] = '{1'b0, 16'h0444, 16'h3000, 3, 12'h444};
        tbl[5] = '{1'b0, 16'hF555, 16'h0000, 0, AVG ? 12'h333 : 12'h555};
        step();
        step();
        chk("init_wrt", wrt, 0);
        chk("init_cmd", cmd, 0);
        chk("init_busy", busy, 0);
        chk("init_lft", lft_ld, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst) do_reset();
            convert(tbl[i].data, 0, cs, cr);
            chk("tbl_cmd", cs, tbl[i].cmd);
            chk("tbl_rd_cmd", cr, 0);
            chk("tbl_val", dres(tbl[i].idx), tbl[i].val);
        end

        // reset while waiting in GAP of a ch4 conversion
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        chk("gap_rst_sel_cmd", cmd, 16'h2000);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("gap_rst_busy", busy, 1);
        do_reset();
        convert(16'h0123, 0, cs, cr);
        chk("gap_rst_ch0", cs, 16'h0000);
        chk("gap_rst_lft", lft_ld, 12'h123);

        // averaging check on lft: 0x100 then 0x201
        do_reset();
        convert(16'h0100, 0, cs, cr);
        chk("avg_first", lft_ld, 12'h100);
        for (int i = 0; i < 3; i++) convert(16'(i + 7), 0, cs, cr);
        convert(16'h0201, 0, cs, cr);
        chk("avg_second", lft_ld, AVG ? 12'h181 : 12'h201);

        // nxt held high through a conversion including the done cycle
        convert(16'h0777, 2, cs, cr);
        chk("hold_nxt_cmd", cs, 16'h2000);

        // spurious done while idle
        done = 1'b1;
        rd_data = 16'h0FFF;
        step();
        done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_cc", cnv_cmplt, 0);
        chk("idle_done_wrt", wrt, 0);
        for (int i = 0; i < 4; i++) chk("idle_done_res", dres(i), m_res[i]);

        for (int k = 0; k < 40; k++) begin
            convert(16'($urandom), 1, cs, cr);
            repeat ($urandom_range(0, 2)) begin
                done = ($urandom_range(0, 1) == 1);
                step();
                done = 1'b0;
                chk("rand_idle_busy", busy, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
